// File: rtl/mem_pkg.sv
// Shared memory-controller protocol definitions.
// Opcodes here must match the controller side bit for bit.
package mem_pkg;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b11
    } mem_op_e;

    localparam int DEF_WORD_SIZE     = 32;
    localparam int DEF_CL_SIZE_WIDTH = 512;
    localparam int DEF_ADDR_BITCOUNT = 64;

endpackage

// File: rtl/mem_req_agent_if.sv
// Upstream (cache/MSHR) request/response bundle of the memory agent.
// master = requester side, slave = agent side.
interface mem_req_agent_if #(
    parameter int CL_SIZE_WIDTH = mem_pkg::DEF_CL_SIZE_WIDTH,
    parameter int ADDR_BITCOUNT = mem_pkg::DEF_ADDR_BITCOUNT
) ();

    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [ADDR_BITCOUNT-1:0] req_addr;
    logic [CL_SIZE_WIDTH-1:0] req_wdata;
    logic                     resp_valid;
    logic                     resp_ready;
    logic                     resp_we;
    logic [CL_SIZE_WIDTH-1:0] resp_rdata;
    logic                     resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_we, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_we, resp_rdata, resp_err
    );

endinterface

// File: rtl/mem_req_agent.sv
// Initiator agent: whole-line requests in, word-serial controller
// traffic out; write lines stream low word first, reads reassemble.
module mem_req_agent
    import mem_pkg::*;
#(
    parameter int WORD_SIZE     = DEF_WORD_SIZE,
    parameter int CL_SIZE_WIDTH = DEF_CL_SIZE_WIDTH,
    parameter int ADDR_BITCOUNT = DEF_ADDR_BITCOUNT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    mem_req_agent_if.slave           up,
    output logic [ADDR_BITCOUNT-1:0] mem_addr,
    output mem_op_e                  ctrl_op,
    input  logic                     ctrl_ready,
    input  logic                     ctrl_tx_done,
    input  logic                     ctrl_rd_valid,
    input  logic [WORD_SIZE-1:0]     ctrl_word_in,
    output logic [WORD_SIZE-1:0]     ctrl_word_out
);

    localparam int N         = CL_SIZE_WIDTH / WORD_SIZE;
    localparam int FILL_BITS = $clog2(N);
    localparam logic [FILL_BITS-1:0] LAST = FILL_BITS'(N - 1);

    typedef enum logic [2:0] {
        WAIT_INIT,
        IDLE,
        WR_ARM,
        WR_FILL,
        WR_WAIT,
        RD_WAIT,
        RESP
    } state_e;

    state_e                   state_q, state_d;
    mem_op_e                  op_q, op_d;
    logic                     rv_q, rv_d;
    logic                     err_q, err_d;
    logic                     we_q, we_d;
    logic [ADDR_BITCOUNT-1:0] addr_q, addr_d;
    logic [CL_SIZE_WIDTH-1:0] buf_q, buf_d;
    logic [FILL_BITS-1:0]     cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_INIT;
            op_q    <= OP_IDLE;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rv_d    = rv_q;
        err_d   = err_q;
        we_d    = we_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        // Losing the controller drops whatever is in flight.
        if (state_q != WAIT_INIT && !ctrl_ready) begin
            state_d = WAIT_INIT;
            op_d    = OP_IDLE;
            rv_d    = 1'b0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                WAIT_INIT: begin
                    if (ctrl_ready) state_d = IDLE;
                end
                IDLE: begin
                    if (up.req_valid) begin
                        addr_d = up.req_addr;
                        buf_d  = up.req_wdata;
                        we_d   = up.req_we;
                        cnt_d  = '0;
                        if (up.req_we) begin
                            op_d    = OP_WRITE;
                            state_d = WR_ARM;
                        end else begin
                            op_d    = OP_READ;
                            state_d = RD_WAIT;
                        end
                    end
                end
                WR_ARM: state_d = WR_FILL;
                WR_FILL: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = WR_WAIT;
                end
                WR_WAIT: begin
                    if (ctrl_tx_done) begin
                        op_d    = OP_IDLE;
                        rv_d    = 1'b1;
                        state_d = RESP;
                    end
                end
                RD_WAIT: begin
                    if (ctrl_rd_valid) begin
                        buf_d = {ctrl_word_in, buf_q[CL_SIZE_WIDTH-1:WORD_SIZE]};
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (ctrl_tx_done) begin
                        op_d    = OP_IDLE;
                        rv_d    = 1'b1;
                        err_d   = (cnt_q != LAST);
                        state_d = RESP;
                    end
                end
                RESP: begin
                    if (up.resp_ready) begin
                        rv_d    = 1'b0;
                        err_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = WAIT_INIT;
            endcase
        end
    end

    logic [WORD_SIZE-1:0] words [N];

    for (genvar k = 0; k < N; k++) begin : g_word
        assign words[k] = buf_q[k*WORD_SIZE +: WORD_SIZE];
    end

    assign ctrl_word_out = words[cnt_q];
    assign ctrl_op       = op_q;
    assign mem_addr      = addr_q;

    assign up.req_ready  = (state_q == IDLE);
    assign up.resp_valid = rv_q;
    assign up.resp_we    = we_q;
    assign up.resp_rdata = buf_q;
    assign up.resp_err   = err_q;

endmodule
